// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_if.sv
// Fetch buses: req/gnt + rvalid towards instruction memory, valid/ready towards decode.
interface fetch_if #(
  parameter int XLEN = fetch_pkg::XLEN_DEF
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  // master = fetch controller, slave = memory + decode side
  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC register: reset load, word-aligned redirect (highest priority), +4 on accepted request.
// Single-cycle update; no handshake of its own.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc
);

  // Clears only the two byte-offset bits, whatever XLEN is.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(~INSTR_ALIGN_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ALIGN_MASK;
    end else if (inc) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: one outstanding imem request, result held for decode until if_ready.
// if_valid rises 2 cycles after imem_req with zero-wait memory; decode stall holds the word in HOLD.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_if.master         bus,
  output logic            busy
);

  fetch_state_e    state;
  fetch_state_e    next_state;
  logic            discard;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            req_accept;

  assign req_accept = (state == REQ) && bus.imem_gnt;

  // A redirect in the grant cycle retargets pc instead of advancing it.
  fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .reset          (reset),
    .inc            (req_accept && !redirect_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = enable ? REQ : IDLE;
      REQ: begin
        if (bus.imem_gnt) next_state = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          if (redirect_valid)  next_state = REQ;
          else if (discard)    next_state = enable ? REQ : IDLE;
          else                 next_state = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || bus.if_ready) next_state = enable ? REQ : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req  = (state == REQ);
    bus.imem_addr = pc;
    busy          = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      discard      <= 1'b0;
      req_pc       <= '0;
      bus.if_valid <= 1'b0;
      bus.if_instr <= '0;
      bus.if_pc    <= '0;
    end else begin
      if (req_accept) begin
        req_pc <= pc;
      end

      // The in-flight response belongs to the old path once a redirect hits REQ+gnt or WAIT.
      if (redirect_valid && (req_accept || (state == WAIT && !bus.imem_rvalid))) begin
        discard <= 1'b1;
      end else if (state == WAIT && bus.imem_rvalid) begin
        discard <= 1'b0;
      end

      if (redirect_valid) begin
        bus.if_valid <= 1'b0;
      end else if (state == WAIT && bus.imem_rvalid && !discard) begin
        bus.if_valid <= 1'b1;
        bus.if_instr <= bus.imem_rdata;
        bus.if_pc    <= req_pc;
      end else if (state == HOLD && bus.if_ready) begin
        bus.if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed scenarios, modelled memory, queue-based decode monitor.
module tb_fetch_controller;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy0;

  logic        enable5;
  logic        redirect5_valid;
  logic [31:0] redirect5_pc;
  logic        busy5;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  exp_t        exp_q[$];
  int          hs_cyc[$];

  fetch_if #(.XLEN(32)) b0 ();
  fetch_if #(.XLEN(32)) b5 ();

  fetch_controller #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut0 (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (b0),
    .busy           (busy0)
  );

  fetch_controller #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut5 (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable5),
    .redirect_valid (redirect5_valid),
    .redirect_pc    (redirect5_pc),
    .bus            (b5),
    .busy           (busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a << 8) | 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model for dut0: grant after gnt_dly cycles of req, rvalid rv_dly cycles after grant.
  int          gnt_dly = 0;
  int          rv_dly  = 1;
  int          wcnt    = 0;
  int          rcnt    = 0;
  bit          pend    = 0;
  logic [31:0] paddr   = 32'h0;
  logic [31:0] last_gnt_addr = 32'hFFFF_FFFF;

  always @(negedge clk) begin
    b0.imem_gnt    = 1'b0;
    b0.imem_rvalid = 1'b0;
    if (pend) begin
      if (rcnt == 0) begin
        b0.imem_rvalid = 1'b1;
        b0.imem_rdata  = mem_data(paddr);
        pend           = 0;
      end else begin
        rcnt--;
      end
    end else if (!reset && b0.imem_req) begin
      if (wcnt >= gnt_dly) begin
        b0.imem_gnt   = 1'b1;
        paddr         = b0.imem_addr;
        last_gnt_addr = paddr;
        pend          = 1;
        rcnt          = rv_dly - 1;
        wcnt          = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Decode-side monitor: every accepted instruction must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && b0.if_valid && b0.if_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h instr %h expected none", b0.if_pc, b0.if_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", b0.if_pc, e.pc);
        chk("sb_instr", b0.if_instr, e.instr);
      end
    end
  end

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(input logic [31:0] exp_addr, input string nm);
    int n = 0;
    do begin
      step();
      n++;
    end while (!b0.imem_gnt && n < 60);
    chk(nm, b0.imem_gnt ? last_gnt_addr : 32'hDEAD_DEAD, exp_addr);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy0 || exp_q.size() != 0 || pend) && n < 100) begin
      step();
      n++;
    end
    chk(nm, {31'b0, busy0}, 32'h0);
    chk({nm, "_drained"}, exp_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int req_cyc;
    reset           = 1'b1;
    enable          = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    b0.if_ready     = 1'b1;
    enable5         = 1'b0;
    redirect5_valid = 1'b0;
    redirect5_pc    = 32'h0;
    b5.imem_gnt     = 1'b0;
    b5.imem_rvalid  = 1'b0;
    b5.imem_rdata   = 32'h0;
    b5.if_ready     = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_req",   b0.imem_req, 32'h0);
    chk("rst_valid", b0.if_valid, 32'h0);
    chk("rst_instr", b0.if_instr, 32'h0);
    chk("rst_pc",    b0.if_pc,    32'h0);
    chk("rst_busy",  busy0,       32'h0);
    chk("rst_addr",  b0.imem_addr, 32'h0);
    chk("rst5_addr", b5.imem_addr, 32'hFFFF_FFFC);

    // 1: back-to-back fetch with zero-wait memory
    push_exp(32'h0, 32'h0000_0013);
    push_exp(32'h4, 32'h0000_0413);
    push_exp(32'h8, 32'h0000_0813);
    enable = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!b0.imem_req && n < 20);
    req_cyc = cyc;
    wait_gnt(32'h0, "t1_addr0");
    wait_gnt(32'h4, "t1_addr4");
    wait_gnt(32'h8, "t1_addr8");
    enable = 1'b0;
    wait_idle("t1_idle");
    if (hs_cyc.size() >= 3) begin
      chk("t1_latency", hs_cyc[0] - req_cyc, 32'd2);
      chk("t1_tput_a",  hs_cyc[1] - hs_cyc[0], 32'd3);
      chk("t1_tput_b",  hs_cyc[2] - hs_cyc[1], 32'd3);
    end else begin
      chk("t1_handshakes", hs_cyc.size(), 32'd3);
    end

    // 2: decode stall holds the word and no new request is made
    push_exp(32'hC,  32'h0000_0C13);
    push_exp(32'h10, 32'h0000_1013);
    b0.if_ready = 1'b0;
    enable      = 1'b1;
    wait_gnt(32'hC, "t2_addr");
    n = 0;
    while (!b0.if_valid && n < 20) begin
      step();
      n++;
    end
    chk("t2_valid", b0.if_valid, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_instr", b0.if_instr, 32'h0000_0C13);
      chk("t2_hold_pc",    b0.if_pc,    32'hC);
      chk("t2_hold_req",   b0.imem_req, 32'h0);
    end
    b0.if_ready = 1'b1;
    wait_gnt(32'h10, "t2_next_addr");
    enable = 1'b0;
    wait_idle("t2_idle");

    // 3: redirect while waiting for a response drops it
    rv_dly = 3;
    push_exp(32'h100, 32'h0001_0013);
    enable = 1'b1;
    wait_gnt(32'h14, "t3_addr");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    wait_gnt(32'h100, "t3_redirect_addr");
    enable = 1'b0;
    wait_idle("t3_idle");

    // 4: redirect in the grant cycle of address 8
    rv_dly         = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    step();
    redirect_valid = 1'b0;
    chk("t4_idle_redirect_busy", busy0, 32'h0);
    push_exp(32'h200, 32'h0002_0013);
    enable = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!b0.imem_req && n < 20);
    chk("t4_req_addr8", b0.imem_addr, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("t4_gnt_same_cycle", b0.imem_gnt, 32'h1);
    wait_gnt(32'h200, "t4_redirect_addr");
    enable = 1'b0;
    wait_idle("t4_idle");

    // 6: reset during WAIT, stray response afterwards
    gnt_dly = 3;
    rv_dly  = 4;
    enable  = 1'b1;
    wait_gnt(32'h204, "t6_addr");
    reset  = 1'b1;
    enable = 1'b0;
    step();
    reset = 1'b0;
    chk("t6_rst_req",   b0.imem_req, 32'h0);
    chk("t6_rst_valid", b0.if_valid, 32'h0);
    chk("t6_rst_instr", b0.if_instr, 32'h0);
    chk("t6_rst_pc",    b0.if_pc,    32'h0);
    chk("t6_rst_busy",  busy0,       32'h0);
    repeat (8) step();
    chk("t6_stray_busy",  busy0,       32'h0);
    chk("t6_stray_valid", b0.if_valid, 32'h0);
    gnt_dly = 0;
    rv_dly  = 1;
    push_exp(32'h0, 32'h0000_0013);
    enable = 1'b1;
    wait_gnt(32'h0, "t6_restart_addr");
    enable = 1'b0;
    wait_idle("t6_idle");

    // 5: PC wrap on the second instance
    enable5 = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!b5.imem_req && n < 20);
    chk("t5_addr0", b5.imem_addr, 32'hFFFF_FFFC);
    b5.imem_gnt = 1'b1;
    step();
    b5.imem_gnt    = 1'b0;
    b5.imem_rvalid = 1'b1;
    b5.imem_rdata  = 32'hDEAD_0013;
    step();
    b5.imem_rvalid = 1'b0;
    chk("t5_valid", b5.if_valid, 32'h1);
    chk("t5_pc",    b5.if_pc,    32'hFFFF_FFFC);
    chk("t5_instr", b5.if_instr, 32'hDEAD_0013);
    step();
    chk("t5_req2",  b5.imem_req,  32'h1);
    chk("t5_addr1", b5.imem_addr, 32'h0);
    enable5     = 1'b0;
    b5.imem_gnt = 1'b1;
    step();
    b5.imem_gnt    = 1'b0;
    b5.imem_rvalid = 1'b1;
    b5.imem_rdata  = 32'h0000_0013;
    step();
    b5.imem_rvalid = 1'b0;
    chk("t5_pc2", b5.if_pc, 32'h0);
    step();
    chk("t5_idle", busy5, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
